sram_mem_controller: RTL and testbench

//  Sequences LDR/STR memory accesses issued by the execute stage onto a 16-bit external SRAM.
//  - Each 32-bit word is moved as two half-word phases: low, then high.
//  - Holds `ready` low while busy so the hazard/freeze logic stalls the pipeline.
//  - Sits between the EXE/MEM pipeline register and the board SRAM pins.
//  - Source signals: ALU result as address, Rm value as store data, mem_read/mem_write flags.

---
 rtl/sram_mem_controller_pkg.sv | 13 +
 rtl/sram_phase_counter.sv | 38 +++
 rtl/sram_mem_controller.sv | 145 ++++++++++++++
 tb/tb_sram_mem_controller.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_mem_controller_pkg.sv
// Shared constants and types for the SRAM memory controller.
// Imported by the controller top and its phase counter.
package sram_mem_controller_pkg;

    // Byte address that maps to SRAM word 0.
    localparam logic [31:0] MEM_BASE_ADDR = 32'd1024;

    // Phase counter width; covers WAIT_CYCLES up to 7.
    localparam int unsigned WAIT_W = 3;

    typedef logic [WAIT_W-1:0] wait_t;

endpackage

// File: rtl/sram_phase_counter.sv
// Loadable down-counter used to time each SRAM half-word phase.
// zero_o flags the last cycle of the current phase.
module sram_phase_counter
    import sram_mem_controller_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              en_i,
    input  logic [WAIT_W-1:0] value_i,
    output logic              zero_o
);

    wait_t count_q;
    wait_t count_d;

    // Load takes priority; otherwise count down and hold at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/sram_mem_controller.sv
// Moves 32-bit LDR/STR words over a 16-bit SRAM as two half-word phases.
// Holds ready low while busy so the pipeline stalls.
module sram_mem_controller
    import sram_mem_controller_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] MEM_BASE    = MEM_BASE_ADDR,
    parameter int unsigned SRAM_ADDR_W = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_read_in,
    input  logic                   mem_write_in,
    input  logic [31:0]            address_in,
    input  logic [31:0]            st_val_in,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [15:0]            sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [15:0]            sram_dq_in,
    output logic                   sram_we_n
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOW  = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam wait_t RELOAD = WAIT_W'(WAIT_CYCLES - 1);

    logic [1:0]             state_q, state_d;
    logic [SRAM_ADDR_W-2:0] wa_q, wa_d;
    logic [31:0]            data_q, data_d;
    logic                   wr_q, wr_d;
    logic [15:0]            lo_q, lo_d;
    logic [31:0]            rdata_q, rdata_d;

    logic        req;
    logic        in_phase;
    logic        cnt_load;
    logic        cnt_zero;
    logic [31:0] eff;
    logic        unused_eff;

    assign req        = mem_read_in | mem_write_in;
    assign eff        = address_in - MEM_BASE;
    assign unused_eff = ^{eff[31:SRAM_ADDR_W+1], eff[1:0]};
    assign in_phase   = (state_q == S_LOW) || (state_q == S_HIGH);
    assign cnt_load   = ((state_q == S_IDLE) && req) || (in_phase && cnt_zero);

    sram_phase_counter u_phase_cnt (
        .clk     (clk),
        .rst     (rst),
        .load_i  (cnt_load),
        .en_i    (in_phase),
        .value_i (RELOAD),
        .zero_o  (cnt_zero)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: one pass through LOW, HIGH and DONE per request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req)      state_d = S_LOW;
            S_LOW:   if (cnt_zero) state_d = S_HIGH;
            S_HIGH:  if (cnt_zero) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Latch the request in IDLE and capture read halves on phase ends.
    always_comb begin
        wa_d    = wa_q;
        data_d  = data_q;
        wr_d    = wr_q;
        lo_d    = lo_q;
        rdata_d = rdata_q;
        if ((state_q == S_IDLE) && req) begin
            wa_d   = eff[SRAM_ADDR_W:2];
            data_d = st_val_in;
            wr_d   = mem_write_in;
        end
        if ((state_q == S_LOW) && cnt_zero && !wr_q) begin
            lo_d = sram_dq_in;
        end
        if ((state_q == S_HIGH) && cnt_zero && !wr_q) begin
            rdata_d = {sram_dq_in, lo_q};
        end
    end

    // Request and read-data registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wa_q    <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            lo_q    <= '0;
            rdata_q <= '0;
        end else begin
            wa_q    <= wa_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            lo_q    <= lo_d;
            rdata_q <= rdata_d;
        end
    end

    // Pin outputs decoded from the current state.
    always_comb begin
        ready       = 1'b0;
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        case (state_q)
            S_IDLE: ready = ~req;
            S_LOW: begin
                sram_addr   = {wa_q, 1'b0};
                sram_dq_out = wr_q ? data_q[15:0] : 16'h0000;
                sram_dq_oe  = wr_q;
                sram_we_n   = ~wr_q;
            end
            S_HIGH: begin
                sram_addr   = {wa_q, 1'b1};
                sram_dq_out = wr_q ? data_q[31:16] : 16'h0000;
                sram_dq_oe  = wr_q;
                sram_we_n   = ~wr_q;
            end
            default: ready = 1'b1;
        endcase
    end

    assign read_data = rdata_q;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Self-checking bench for sram_mem_controller (WAIT_CYCLES 1 and 3).
// Vector table plus scoreboard queues of expected SRAM phases and load data.
module tb_sram_mem_controller;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [16:0] wa;
        bit          scr;
        logic [31:0] exp_rd;
    } vec_t;

    typedef struct packed {
        logic [17:0] a;
        logic        we_n;
        logic        oe;
        logic [15:0] d;
    } ph_t;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        rd   = 1'b0;
    logic        wr   = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] data = '0;

    logic [31:0] rdata1, rdata3;
    logic        ready1, ready3;
    logic [17:0] saddr1, saddr3;
    logic [15:0] dqo1, dqo3, dqi1, dqi3;
    logic        oe1, oe3, wen1, wen3;

    logic [15:0] rom [16];
    bit          sel = 1'b0;

    logic [31:0] rdata_v;
    logic        ready_v, oe_v, wen_v;
    logic [17:0] saddr_v;
    logic [15:0] dqo_v;

    int          checks = 0;
    int          errors = 0;
    ph_t         phq[$];
    logic [31:0] rdq[$];
    vec_t        vecs [6];
    vec_t        v3 [2];

    always #5 clk = ~clk;

    assign dqi1 = rom[saddr1[3:0]];
    assign dqi3 = rom[saddr3[3:0]];

    assign rdata_v = sel ? rdata3 : rdata1;
    assign ready_v = sel ? ready3 : ready1;
    assign saddr_v = sel ? saddr3 : saddr1;
    assign dqo_v   = sel ? dqo3   : dqo1;
    assign oe_v    = sel ? oe3    : oe1;
    assign wen_v   = sel ? wen3   : wen1;

    sram_mem_controller #(.WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst),
        .mem_read_in(rd), .mem_write_in(wr),
        .address_in(addr), .st_val_in(data),
        .read_data(rdata1), .ready(ready1),
        .sram_addr(saddr1), .sram_dq_out(dqo1),
        .sram_dq_oe(oe1), .sram_dq_in(dqi1),
        .sram_we_n(wen1)
    );

    sram_mem_controller #(.WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst),
        .mem_read_in(rd), .mem_write_in(wr),
        .address_in(addr), .st_val_in(data),
        .read_data(rdata3), .ready(ready3),
        .sram_addr(saddr3), .sram_dq_out(dqo3),
        .sram_dq_oe(oe3), .sram_dq_in(dqi3),
        .sram_we_n(wen3)
    );

    task automatic chk(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input int w);
        ph_t         p;
        ph_t         got;
        int          lat;
        bit          done;
        logic [31:0] er;
        @(posedge clk);
        #1;
        rd   = v.rd;
        wr   = v.wr;
        addr = v.addr;
        data = v.data;
        for (int h = 0; h < 2; h++) begin
            for (int k = 0; k < w; k++) begin
                p.a    = {v.wa, h[0]};
                p.we_n = ~v.wr;
                p.oe   = v.wr;
                p.d    = (h == 0) ? v.data[15:0] : v.data[31:16];
                phq.push_back(p);
            end
        end
        rdq.push_back(v.exp_rd);
        @(negedge clk);
        chk(ready_v == 1'b0, "stall_c0", 64'(ready_v), 64'd0);
        lat  = 1;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(posedge clk);
            #1;
            if (v.scr && c == 0) begin
                addr = $urandom;
                data = $urandom;
            end
            @(negedge clk);
            if (ready_v) begin
                done = 1'b1;
            end else begin
                lat++;
                got = {saddr_v, wen_v, oe_v, dqo_v};
                if (phq.size() == 0) begin
                    chk(1'b0, "phase_extra", 64'(got), 64'd0);
                end else begin
                    p = phq.pop_front();
                    if (!p.we_n)
                        chk(got == p, "phase_wr", 64'(got), 64'(p));
                    else
                        chk(got.a == p.a && got.we_n && !got.oe,
                            "phase_rd", 64'(got), 64'(p));
                end
            end
        end
        chk(done, "done_timeout", 64'(lat), 64'(2 * w + 1));
        chk(lat == 2 * w + 1, "latency", 64'(lat), 64'(2 * w + 1));
        er = rdq.pop_front();
        chk(rdata_v == er, "read_data", 64'(rdata_v), 64'(er));
        chk(phq.size() == 0, "phase_missing", 64'(phq.size()), 64'd0);
        phq.delete();
        @(posedge clk);
        #1;
        rd   = 1'b0;
        wr   = 1'b0;
        addr = '0;
        data = '0;
        @(negedge clk);
        chk(ready_v && wen_v && !oe_v, "idle_after",
            64'({ready_v, wen_v, oe_v}), 64'(3'b110));
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
        rom[0] = 16'h1111;
        rom[1] = 16'h2222;
        rom[2] = 16'h1234;
        rom[3] = 16'h5678;
        rom[4] = 16'hAAAA;
        rom[5] = 16'hBBBB;

        vecs[0] = '{1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF, 17'd1, 1'b0, 32'h0000_0000};
        vecs[1] = '{1'b1, 1'b0, 32'd1028, 32'h0000_0000, 17'd1, 1'b0, 32'h5678_1234};
        vecs[2] = '{1'b1, 1'b1, 32'd1032, 32'hCAFE_F00D, 17'd2, 1'b0, 32'h5678_1234};
        vecs[3] = '{1'b1, 1'b0, 32'd1034, 32'h0000_0000, 17'd2, 1'b0, 32'hBBBB_AAAA};
        vecs[4] = '{1'b1, 1'b0, 32'd0,    32'h0000_0000, 17'h1FF00, 1'b0, 32'h2222_1111};
        vecs[5] = '{1'b0, 1'b1, 32'd1040, 32'h0123_4567, 17'd4, 1'b1, 32'h2222_1111};

        v3[0] = '{1'b0, 1'b1, 32'd1024, 32'h0000_5555, 17'd0, 1'b0, 32'h0000_0000};
        v3[1] = '{1'b1, 1'b0, 32'd1028, 32'h0000_0000, 17'd1, 1'b0, 32'h5678_1234};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk(ready1 && wen1 && !oe1, "rst_ctl", 64'({ready1, wen1, oe1}), 64'(3'b110));
        chk(saddr1 == '0 && dqo1 == '0, "rst_pins", 64'({saddr1, dqo1}), 64'd0);
        chk(rdata1 == '0, "rst_rdata", 64'(rdata1), 64'd0);
        chk(ready3 && wen3 && !oe3 && rdata3 == '0, "rst_dut3",
            64'({ready3, wen3, oe3}), 64'(3'b110));

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk(ready1 && wen1 && !oe1, "idle1", 64'({ready1, wen1, oe1}), 64'(3'b110));
            chk(ready3 && wen3 && !oe3, "idle3", 64'({ready3, wen3, oe3}), 64'(3'b110));
        end

        for (int i = 0; i < 6; i++) run(vecs[i], 1);

        @(posedge clk);
        #1;
        wr   = 1'b1;
        addr = 32'd1028;
        data = 32'h9999_7777;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk(!wen1 && saddr1 == 18'd3 && dqo1 == 16'h9999, "rst_pre_high",
            64'({wen1, saddr1, dqo1}), 64'({1'b0, 18'd3, 16'h9999}));
        @(posedge clk);
        #1;
        rst  = 1'b0;
        wr   = 1'b0;
        addr = '0;
        data = '0;
        @(negedge clk);
        chk(ready1 && wen1 && !oe1, "rst_mid_ctl", 64'({ready1, wen1, oe1}), 64'(3'b110));
        chk(rdata1 == '0 && saddr1 == '0, "rst_mid_data",
            64'({rdata1, saddr1}), 64'd0);

        sel = 1'b1;
        for (int i = 0; i < 2; i++) run(v3[i], 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
